// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if
//   Bundles the two requester handshakes (CPU MEM stage, IO buffer engine)
//   and the external data-memory port shared between them.
//   slave  : arbiter view (takes requests + memory read data, drives acks,
//            read data and the memory address/data/write-enable).
//   master : environment view (requesters and memory model).
interface dm_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // CPU requester
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;
    // IO requester
    logic          io_req;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;
    logic          io_ack;
    // data-memory port
    logic [AW-1:0] address_DM;
    logic [DW-1:0] data_out_DM;
    logic          OUT_MW;
    logic [DW-1:0] data_in_DM;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  io_req, io_we, io_addr, io_wdata,
        output io_rdata, io_ack,
        output address_DM, data_out_DM, OUT_MW,
        input  data_in_DM
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output io_req, io_we, io_addr, io_wdata,
        input  io_rdata, io_ack,
        input  address_DM, data_out_DM, OUT_MW,
        output data_in_DM
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single data-memory port between the CPU MEM stage (high
//   priority) and the IO buffer engine (low priority, starvation guarded).
//   One transaction in flight: IDLE (arbitrate) -> ACCESS (drive memory)
//   -> [RDATA (return read data)] -> IDLE.
// Ports:
//   main_clk : rising-edge clock
//   rst      : asynchronous active-low reset
//   bus      : requester handshakes + memory port (dm_port_arbiter_if.slave)
module dm_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                main_clk,
    input  logic                rst,
    dm_port_arbiter_if.slave    bus
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t        state_q, state_d;
    logic          owner_q;      // 0 = CPU, 1 = IO
    logic          we_q;
    logic [AW-1:0] addr_q;       // doubles as address_DM: holds between transactions
    logic [DW-1:0] wdata_q;      // doubles as data_out_DM
    logic [3:0]    starve_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] io_rdata_q;

    logic any_req;
    logic io_wins;
    logic done;

    // IO wins when alone, or when it has lost MAX_WAIT arbitrations in a row.
    assign any_req = bus.cpu_req | bus.io_req;
    assign io_wins = bus.io_req & (~bus.cpu_req | (starve_q == MAX_W));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion: writes finish in ACCESS, reads in RDATA. Decoded from
    // state so acks and OUT_MW fall asynchronously with reset.
    assign done = ((state_q == ACCESS) & we_q) | (state_q == RDATA);

    assign bus.cpu_ack     = done & ~owner_q;
    assign bus.io_ack      = done &  owner_q;
    assign bus.cpu_stall   = bus.cpu_req & ~bus.cpu_ack;
    assign bus.OUT_MW      = (state_q == ACCESS) & we_q;
    assign bus.address_DM  = addr_q;
    assign bus.data_out_DM = wdata_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.io_rdata    = io_rdata_q;

    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE) begin
                if (any_req) begin
                    owner_q <= io_wins;
                    we_q    <= io_wins ? bus.io_we    : bus.cpu_we;
                    addr_q  <= io_wins ? bus.io_addr  : bus.cpu_addr;
                    wdata_q <= io_wins ? bus.io_wdata : bus.cpu_wdata;
                end
                // Count only arbitrations IO actually contested and lost.
                if (!bus.io_req || io_wins)
                    starve_q <= '0;
                else if (starve_q != MAX_W)
                    starve_q <= starve_q + 4'd1;
            end

            // Memory read data is valid during ACCESS; register it so it
            // is visible to the owner in the RDATA/ack cycle.
            if (state_q == ACCESS && !we_q) begin
                if (owner_q) io_rdata_q  <= bus.data_in_DM;
                else         cpu_rdata_q <= bus.data_in_DM;
            end
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MAX_WAIT = 4;

    logic main_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 main_clk = ~main_clk;

    dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .main_clk (main_clk),
        .rst      (rst),
        .bus      (bus)
    );

    // memory model: combinational read of the presented address,
    // write sampled mid-cycle while OUT_MW is asserted
    logic [7:0] mem [256];
    assign bus.data_in_DM = mem[bus.address_DM];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h20] = 8'h3C;
        mem[8'h01] = 8'h77;
        mem[8'h30] = 8'hE1;
        forever begin
            @(negedge main_clk);
            if (bus.OUT_MW) mem[bus.address_DM] = bus.data_out_DM;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        bit         io;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t sbq[$];

    function automatic void expect_txn(bit io, bit we, logic [7:0] a, logic [7:0] wd, logic [7:0] rd);
        exp_t e;
        e.io = io; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
        sbq.push_back(e);
    endfunction

    // monitor: pops one expectation per ack and checks the memory side
    // and both rdata registers (the non-owner's must stay unchanged)
    exp_t       m_e;
    logic [7:0] exp_cpu_rd, exp_io_rd;
    logic       prev_ack;
    always @(negedge main_clk) begin
        if (!rst) begin
            exp_cpu_rd = 8'h00;
            exp_io_rd  = 8'h00;
            prev_ack   = 1'b0;
        end else begin
            if (bus.cpu_ack || bus.io_ack) begin
                chk("dual_ack", 32'(bus.cpu_ack & bus.io_ack), 32'd0);
                chk("ack_pulse_width", 32'(prev_ack), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", {bus.cpu_ack, bus.io_ack}, 32'd0);
                end else begin
                    m_e = sbq.pop_front();
                    chk("ack_owner", 32'(bus.io_ack), 32'(m_e.io));
                    chk("address_DM", 32'(bus.address_DM), 32'(m_e.addr));
                    chk("OUT_MW_at_ack", 32'(bus.OUT_MW), 32'(m_e.we));
                    if (m_e.we)
                        chk("data_out_DM", 32'(bus.data_out_DM), 32'(m_e.wdata));
                    else if (m_e.io)
                        exp_io_rd = m_e.rdata;
                    else
                        exp_cpu_rd = m_e.rdata;
                end
                chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu_rd));
                chk("io_rdata", 32'(bus.io_rdata), 32'(exp_io_rd));
            end
            prev_ack = bus.cpu_ack | bus.io_ack;
        end
    end

    // Issue one request (caller is just after a rising edge), hold until ack,
    // drop at the ack edge. exp_lat < 0 skips the latency check.
    task automatic op(input bit is_io, input bit we, input logic [7:0] a,
                      input logic [7:0] d, input int exp_lat, output bit other_req);
        int lat = 0;
        bit got = 0;
        other_req = 0;
        if (is_io) begin
            bus.io_req = 1; bus.io_we = we; bus.io_addr = a; bus.io_wdata = d;
        end else begin
            bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge main_clk);
            lat++;
            if (is_io ? bus.io_ack : bus.cpu_ack) begin
                got = 1;
                other_req = is_io ? bus.cpu_req : bus.io_req;
                if (!is_io) chk("cpu_stall_at_ack", 32'(bus.cpu_stall), 32'd0);
                break;
            end
            if (!is_io) chk("cpu_stall_waiting", 32'(bus.cpu_stall), 32'd1);
        end
        if (!got) chk(is_io ? "io_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) chk(is_io ? "io_latency" : "cpu_latency", 32'(lat - 1), 32'(exp_lat));
        @(posedge main_clk);
        #1;
        if (is_io) bus.io_req = 0;
        else       bus.cpu_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit oth, oth2;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.io_req  = 0; bus.io_we  = 0; bus.io_addr  = 0; bus.io_wdata  = 0;

        // reset state
        #1 rst = 1'b0;
        #2;
        chk("rst_address_DM", 32'(bus.address_DM), 32'd0);
        chk("rst_data_out_DM", 32'(bus.data_out_DM), 32'd0);
        chk("rst_OUT_MW", 32'(bus.OUT_MW), 32'd0);
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_io_rdata", 32'(bus.io_rdata), 32'd0);
        chk("rst_acks", {bus.cpu_ack, bus.io_ack}, 32'd0);
        @(posedge main_clk);
        @(posedge main_clk); #1 rst = 1'b1;
        @(posedge main_clk); #1;

        // CPU write 0x10 = 0xA5, ack one cycle after arbitration
        expect_txn(0, 1, 8'h10, 8'hA5, 8'h00);
        op(0, 1, 8'h10, 8'hA5, 1, oth);
        @(negedge main_clk);
        chk("OUT_MW_after_write", 32'(bus.OUT_MW), 32'd0);
        chk("mem_10", 32'(mem[8'h10]), 32'hA5);
        @(posedge main_clk); #1;

        // CPU read 0x20 -> 0x3C, ack two cycles after arbitration
        expect_txn(0, 0, 8'h20, 8'h00, 8'h3C);
        op(0, 0, 8'h20, 8'h00, 2, oth);

        // simultaneous: CPU read 0x01 first, then IO write 0x80 = 0x11
        expect_txn(0, 0, 8'h01, 8'h00, 8'h77);
        expect_txn(1, 1, 8'h80, 8'h11, 8'h00);
        fork
            op(0, 0, 8'h01, 8'h00, 2, oth);
            op(1, 1, 8'h80, 8'h11, 4, oth2);
        join
        chk("mem_80", 32'(mem[8'h80]), 32'h11);

        // starvation: IO loses 4 arbitrations, wins the 5th while CPU still asks
        for (int i = 0; i < 4; i++) expect_txn(0, 1, 8'(8'h40 + i), 8'(8'hC0 + i), 8'h00);
        expect_txn(1, 1, 8'h90, 8'h22, 8'h00);
        expect_txn(0, 1, 8'h44, 8'hC4, 8'h00);
        fork
            begin
                for (int i = 0; i < 5; i++) op(0, 1, 8'(8'h40 + i), 8'(8'hC0 + i), -1, oth);
            end
            begin
                op(1, 1, 8'h90, 8'h22, 9, oth2);
                chk("cpu_req_at_io_ack", 32'(oth2), 32'd1);
            end
        join

        // counter cleared after the grant: CPU wins the next contention
        expect_txn(0, 1, 8'h50, 8'h33, 8'h00);
        expect_txn(1, 0, 8'h30, 8'h00, 8'hE1);
        fork
            op(0, 1, 8'h50, 8'h33, 1, oth);
            op(1, 0, 8'h30, 8'h00, 4, oth2);
        join

        // reset during ACCESS of an IO read: everything drops, no ack
        bus.io_req = 1; bus.io_we = 0; bus.io_addr = 8'h30; bus.io_wdata = 8'h00;
        @(posedge main_clk); #1;
        chk("pre_rst_address_DM", 32'(bus.address_DM), 32'h30);
        rst = 1'b0;
        #1;
        chk("midrst_address_DM", 32'(bus.address_DM), 32'd0);
        chk("midrst_data_out_DM", 32'(bus.data_out_DM), 32'd0);
        chk("midrst_OUT_MW", 32'(bus.OUT_MW), 32'd0);
        chk("midrst_io_rdata", 32'(bus.io_rdata), 32'd0);
        chk("midrst_acks", {bus.cpu_ack, bus.io_ack}, 32'd0);
        bus.io_req = 0;
        @(posedge main_clk);
        @(posedge main_clk); #1 rst = 1'b1;
        @(posedge main_clk); #1;

        // first request after reset served normally, then idle hold
        expect_txn(0, 1, 8'h44, 8'h99, 8'h00);
        op(0, 1, 8'h44, 8'h99, 1, oth);
        for (int i = 0; i < 5; i++) begin
            @(negedge main_clk);
            chk("idle_address_DM", 32'(bus.address_DM), 32'h44);
            chk("idle_data_out_DM", 32'(bus.data_out_DM), 32'h99);
            chk("idle_OUT_MW", 32'(bus.OUT_MW), 32'd0);
            chk("idle_acks", {bus.cpu_ack, bus.io_ack}, 32'd0);
        end

        repeat (2) @(negedge main_clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
